// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and the pixel coordinate type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int COORD_LIMIT   = 1024;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL  = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL  = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  // Sync windows are half-open: [START, END).
  localparam int HS_START = H_VISIBLE_DEF + H_FP_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_VISIBLE_DEF + V_FP_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

endpackage

// File: rtl/vga_timing_if.sv
// Bundle of pixel-position, blanking, sync and frame-strobe signals from the timing source.
// Latency: n/a (wires only).
// Backpressure: none; consumers sample every vga_clk.
interface vga_timing_if;
  import vga_timing_pkg::*;

  coord_t      DrawX;
  coord_t      DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        frame_clk;
  logic [15:0] frame_count;

  modport master (output DrawX, DrawY, blank, hs, vs, frame_clk, frame_count);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_clk, frame_count);
endinterface

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-MOD up-counter with a combinational wrap flag on the terminal enabled count.
// Latency: count is registered; wrap is valid in the same cycle as count == MOD-1.
// Backpressure: none; en simply holds the count.
module mod_counter #(
  parameter int MOD   = 800,
  parameter int WIDTH = 10
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: hold when disabled, return to zero after the last value.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign wrap  = en && (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel timing source: DrawX/DrawY counters, blank, active-low hs/vs, frame strobe and counter.
// Latency: every output registered; decode uses next counter values so all outputs describe the same pixel.
// Backpressure: none; free-running one pixel per vga_clk.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic        vga_clk,
  input  logic        reset,
  vga_timing_if.master vga
);

  localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t HV_C = coord_t'(H_VISIBLE);
  localparam coord_t VV_C = coord_t'(V_VISIBLE);
  localparam coord_t HS_S = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_E = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_S = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_E = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  // Reject timings that are empty or that would overflow the 10-bit coordinates.
  if (H_VISIBLE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_VISIBLE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
      HT > COORD_LIMIT || VT > COORD_LIMIT) begin : g_bad_timing
    $error("vga_timing_gen: illegal timing parameters");
  end

  coord_t      x;
  coord_t      y;
  logic        h_wrap;
  logic        v_wrap;

  coord_t      x_d;
  coord_t      y_d;
  logic        blank_d, hs_d, vs_d, frame_clk_d;
  logic [15:0] frame_count_d;
  logic        blank_q, hs_q, vs_q, frame_clk_q;
  logic [15:0] frame_count_q;

  mod_counter #(.MOD(HT), .WIDTH(10)) u_hcnt (
    .vga_clk (vga_clk),
    .reset   (reset),
    .en      (1'b1),
    .count   (x),
    .wrap    (h_wrap)
  );

  mod_counter #(.MOD(VT), .WIDTH(10)) u_vcnt (
    .vga_clk (vga_clk),
    .reset   (reset),
    .en      (h_wrap),
    .count   (y),
    .wrap    (v_wrap)
  );

  // Decode from the values the counters take on the next edge, so registered flags line up with them.
  always_comb begin
    x_d           = h_wrap ? '0 : x + 1'b1;
    y_d           = v_wrap ? '0 : (h_wrap ? y + 1'b1 : y);
    blank_d       = (x_d < HV_C) && (y_d < VV_C);
    hs_d          = !((x_d >= HS_S) && (x_d < HS_E));
    vs_d          = !((y_d >= VS_S) && (y_d < VS_E));
    frame_clk_d   = (x_d == '0) && (y_d == VV_C);
    frame_count_d = v_wrap ? frame_count_q + 16'd1 : frame_count_q;
  end

  // Output flag registers; reset state describes visible pixel (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank_q       <= 1'b1;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_clk_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_clk_q   <= frame_clk_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vga.DrawX       = x;
  assign vga.DrawY       = y;
  assign vga.blank       = blank_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.frame_clk   = frame_clk_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a reduced-timing instance share one clock.
// Latency: expected pixel state is queued before each edge and compared 1 time unit after it.
// Backpressure: n/a.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // Reduced timing for frame-level scenarios: 25 x 19 = 475 clocks per frame.
  localparam int S_HV = 16, S_HFP = 2, S_HSY = 4, S_HBP = 3;
  localparam int S_VV = 12, S_VFP = 2, S_VSY = 2, S_VBP = 3;
  localparam int S_HT = S_HV + S_HFP + S_HSY + S_HBP;
  localparam int S_VT = S_VV + S_VFP + S_VSY + S_VBP;
  localparam int D_HT = 800, D_VT = 525;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        fclk;
    logic [15:0] fc;
  } obs_t;

  localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, blank: 1'b1, hs: 1'b1, vs: 1'b1, fclk: 1'b0, fc: 16'd0};

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if vif_d ();
  vga_timing_if vif_s ();

  vga_timing_gen dut_d (.vga_clk(clk), .reset(rst_d), .vga(vif_d));

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP)
  ) dut_s (.vga_clk(clk), .reset(rst_s), .vga(vif_s));

  int checks = 0;
  int errors = 0;

  obs_t sbq_d[$];
  obs_t sbq_s[$];

  // Reference pixel positions
  int mx_d = 0, my_d = 0, mfc_d = 0;
  int mx_s = 0, my_s = 0, mfc_s = 0;

  obs_t od, os;

  // Line-0 statistics for the default instance
  int hs_lo_d = 0, hs_first_d = -1, hs_last_d = -1, blank_line_d = 0;
  // Single-frame statistics for the reduced instance
  bit win = 1'b0;
  int vs_lo_s = 0, blank_s = 0, bad_blank_s = 0, fclk_s = 0, fclk_x = -1, fclk_y = -1;

  function automatic obs_t predict(int x, int y, int fc, int hv, int hfp, int hsy,
                                   int vv, int vfp, int vsy);
    obs_t o;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = (x < hv) && (y < vv);
    o.hs    = !((x >= hv + hfp) && (x < hv + hfp + hsy));
    o.vs    = !((y >= vv + vfp) && (y < vv + vfp + vsy));
    o.fclk  = (x == 0) && (y == vv);
    o.fc    = 16'(fc);
    return o;
  endfunction

  function automatic obs_t get_d();
    obs_t o;
    o.x = vif_d.DrawX; o.y = vif_d.DrawY; o.blank = vif_d.blank; o.hs = vif_d.hs;
    o.vs = vif_d.vs; o.fclk = vif_d.frame_clk; o.fc = vif_d.frame_count;
    return o;
  endfunction

  function automatic obs_t get_s();
    obs_t o;
    o.x = vif_s.DrawX; o.y = vif_s.DrawY; o.blank = vif_s.blank; o.hs = vif_s.hs;
    o.vs = vif_s.vs; o.fclk = vif_s.frame_clk; o.fc = vif_s.frame_count;
    return o;
  endfunction

  task automatic chk(string tag, obs_t got, obs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got x=%0d y=%0d blank=%0b hs=%0b vs=%0b fclk=%0b fc=%0d exp x=%0d y=%0d blank=%0b hs=%0b vs=%0b fclk=%0b fc=%0d",
             tag, got.x, got.y, got.blank, got.hs, got.vs, got.fclk, got.fc,
             exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.fclk, exp.fc);
    end
  endtask

  task automatic chki(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic stats_d(obs_t o);
    if (o.y == 10'd0) begin
      if (!o.hs) begin
        hs_lo_d++;
        if (hs_first_d < 0) hs_first_d = int'(o.x);
        hs_last_d = int'(o.x);
      end
      if (o.blank) blank_line_d++;
    end
  endtask

  task automatic stats_s(obs_t o);
    if (win) begin
      if (!o.vs) vs_lo_s++;
      if (o.blank) blank_s++;
      if (o.blank && (o.x >= 10'(S_HV) || o.y >= 10'(S_VV))) bad_blank_s++;
      if (o.fclk) begin
        fclk_s++;
        fclk_x = int'(o.x);
        fclk_y = int'(o.y);
      end
    end
  endtask

  // One clock: advance reference, queue its prediction, then compare the DUT after the edge.
  task automatic tick();
    if (!rst_d) begin
      mx_d++;
      if (mx_d == D_HT) begin
        mx_d = 0; my_d++;
        if (my_d == D_VT) begin my_d = 0; mfc_d = (mfc_d + 1) % 65536; end
      end
    end
    if (!rst_s) begin
      mx_s++;
      if (mx_s == S_HT) begin
        mx_s = 0; my_s++;
        if (my_s == S_VT) begin my_s = 0; mfc_s = (mfc_s + 1) % 65536; end
      end
    end
    sbq_d.push_back(predict(mx_d, my_d, mfc_d, 640, 16, 96, 480, 10, 2));
    sbq_s.push_back(predict(mx_s, my_s, mfc_s, S_HV, S_HFP, S_HSY, S_VV, S_VFP, S_VSY));
    @(posedge clk);
    #1;
    od = get_d();
    os = get_s();
    chk("sb_d", od, sbq_d.pop_front());
    chk("sb_s", os, sbq_s.pop_front());
    stats_d(od);
    stats_s(os);
  endtask

  initial begin
    int n;
    bit found;
    int fc_before;

    // Reset held across several edges: reset values must persist.
    repeat (3) @(posedge clk);
    #1;
    od = get_d();
    os = get_s();
    chk("reset_d", od, RST_OBS);
    chk("reset_s", os, RST_OBS);
    stats_d(od);

    // Release mid-cycle; first edge gives DrawX=1.
    rst_d = 1'b0;
    rst_s = 1'b0;
    tick();
    chki("first_x_d", int'(od.x), 1);
    chki("first_y_d", int'(od.y), 0);

    // Default line 0 until DrawY advances.
    n = 1;
    found = 1'b0;
    for (int i = 0; i < 900 && !found; i++) begin
      tick();
      n++;
      if (od.y == 10'd1) found = 1'b1;
    end
    chki("line_wrap_found", int'(found), 1);
    chki("line_wrap_cycles", n, 800);
    chki("line_wrap_x", int'(od.x), 0);
    chki("hs_low_count", hs_lo_d, 96);
    chki("hs_low_first", hs_first_d, 656);
    chki("hs_low_last", hs_last_d, 751);
    chki("blank_line0", blank_line_d, 640);

    // Reduced instance: collect one whole frame starting at (0,0).
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (os.x == 10'd0 && os.y == 10'd0) found = 1'b1;
    end
    chki("frame_start_found", int'(found), 1);
    win = 1'b1;
    stats_s(os);
    repeat (S_HT * S_VT - 1) tick();
    win = 1'b0;
    chki("frame_end_x", int'(os.x), S_HT - 1);
    chki("frame_end_y", int'(os.y), S_VT - 1);
    chki("vs_low_count", vs_lo_s, S_VSY * S_HT);
    chki("blank_count", blank_s, S_HV * S_VV);
    chki("blank_outside", bad_blank_s, 0);
    chki("fclk_count", fclk_s, 1);
    chki("fclk_x", fclk_x, 0);
    chki("fclk_y", fclk_y, S_VV);
    fc_before = int'(os.fc);
    tick();
    chki("fc_increment", int'(os.fc), fc_before + 1);
    chki("fc_value", int'(os.fc), 3);

    // Asynchronous reset in the middle of the reduced frame.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (os.x == 10'd15 && os.y == 10'd10) found = 1'b1;
    end
    chki("mid_point_found", int'(found), 1);
    #2;
    rst_s = 1'b1;
    mx_s = 0; my_s = 0; mfc_s = 0;
    #1;
    chk("async_reset", get_s(), RST_OBS);
    repeat (3) tick();
    #1;
    rst_s = 1'b0;
    tick();
    chki("after_rst_x", int'(os.x), 1);
    chki("after_rst_y", int'(os.y), 0);
    chki("after_rst_fc", int'(os.fc), 0);

    // Preload the frame counter to its maximum and let it wrap.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (os.x == 10'd3 && os.y == 10'd5) found = 1'b1;
    end
    chki("preload_point_found", int'(found), 1);
    force dut_s.frame_count_q = 16'hFFFF;
    #1;
    release dut_s.frame_count_q;
    mfc_s = 65535;
    tick();
    chki("preload_held", int'(os.fc), 65535);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (os.x == 10'd0 && os.y == 10'd0) found = 1'b1;
    end
    chki("fc_wrap_found", int'(found), 1);
    chki("fc_wrap_value", int'(os.fc), 0);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
